// File: rtl/seq_mult_bcd_display_if.sv
// Operand/result bundle for seq_mult_bcd_display.
// The master drives the operands; the slave returns the product and the seven-segment digits.
interface seq_mult_bcd_display_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
);
  logic                   valid;
  logic                   ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   done;
  logic [2*WIDTH-1:0]     result;
  logic [7*DIGITS-1:0]    segments;

  modport master (output valid, a, b, input ready, done, result, segments);
  modport slave  (input valid, a, b, output ready, done, result, segments);
endinterface

// File: rtl/seq_mult_bcd_display.sv
// Sequential shift-add multiplier, double-dabble BCD conversion and seven-segment readout.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the digits above the most significant non-zero digit.
module seq_mult_bcd_display #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  seq_mult_bcd_display_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(PW) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) add3 = n + 4'd3;
    else           add3 = n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Encoding an all-zero BCD word also yields the reset display pattern.
  function automatic logic [SW-1:0] encode(input logic [BW-1:0] bcd);
    logic lead;
    encode = {SW{1'b0}};
    lead   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
      if ((k == 0) || (bcd[4*k +: 4] != 4'd0)) lead = 1'b0;
      else                                     lead = lead;
      encode[7*k +: 7] = lead ? 7'h00 : seg7(bcd[4*k +: 4]);
`else
      encode[7*k +: 7] = seg7(bcd[4*k +: 4]);
`endif
    end
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_bin;
  logic [BW-1:0]   r_bcd;
  logic [PW-1:0]   r_result;
  logic [SW-1:0]   r_segments;
  logic [PW-1:0]   w_acc_nxt;
  logic [BW-1:0]   w_bcd_adj;
  logic [BW-1:0]   w_bcd_shift;
  logic            w_last_mult;
  logic            w_last_conv;

  assign w_last_mult = (r_cnt == CW'(WIDTH - 1));
  assign w_last_conv = (r_cnt == CW'(PW - 1));
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      w_bcd_adj[4*k +: 4] = add3(r_bcd[4*k +: 4]);
    end
    w_bcd_shift = {w_bcd_adj[BW-2:0], r_bin[PW-1]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.valid) w_state_nxt = S_MULT;
        else           w_state_nxt = S_IDLE;
      end
      S_MULT: begin
        if (w_last_mult) w_state_nxt = S_CONV;
        else             w_state_nxt = S_MULT;
      end
      S_CONV: begin
        if (w_last_conv) w_state_nxt = S_DONE;
        else             w_state_nxt = S_CONV;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath; the visible result only changes on the final CONV edge (entering DONE).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= {CW{1'b0}};
      r_mcand    <= {PW{1'b0}};
      r_mplier   <= {WIDTH{1'b0}};
      r_acc      <= {PW{1'b0}};
      r_bin      <= {PW{1'b0}};
      r_bcd      <= {BW{1'b0}};
      r_result   <= {PW{1'b0}};
      r_segments <= encode({BW{1'b0}});
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_acc    <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
          end
        end
        S_MULT: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last_mult) begin
            r_bin <= w_acc_nxt;
            r_bcd <= {BW{1'b0}};
            r_cnt <= {CW{1'b0}};
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CONV: begin
          r_bcd <= w_bcd_shift;
          r_bin <= r_bin << 1;
          if (w_last_conv) begin
            r_result   <= r_acc;
            r_segments <= encode(w_bcd_shift);
            r_cnt      <= {CW{1'b0}};
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.result   = r_result;
  assign bus.segments = r_segments;
endmodule

// File: tb/tb_seq_mult_bcd_display.sv
// Scoreboard bench for seq_mult_bcd_display at WIDTH=4/DIGITS=3 and WIDTH=8/DIGITS=5.
module tb_seq_mult_bcd_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mult_bcd_display_if #(.WIDTH(4), .DIGITS(3)) b4 ();
  seq_mult_bcd_display_if #(.WIDTH(8), .DIGITS(5)) b8 ();

  seq_mult_bcd_display #(.WIDTH(4), .DIGITS(3)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(b4));
  seq_mult_bcd_display #(.WIDTH(8), .DIGITS(5)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));

  typedef struct {
    logic [15:0] res;
    logic [34:0] seg;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic logic [6:0] tb_seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [34:0] model_seg(input int unsigned v, input int nd);
    logic [34:0] s;
    int unsigned p;
    s = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) s[7*k +: 7] = 7'h00;
      else                s[7*k +: 7] = tb_seg(int'((v / p) % 10));
`else
      s[7*k +: 7] = tb_seg(int'((v / p) % 10));
`endif
      p = p * 10;
    end
    return s;
  endfunction

  // One WIDTH=4 operation; wait_n = cycles spent waiting for o_ready before transfer.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit keep_valid,
                      input string tag, output int wait_n);
    exp_t e;
    int lat;
    bit rl;
    e.res = 16'(a * b);
    e.seg = model_seg(int'(a) * int'(b), 3);
    sb.push_back(e);
    b4.a = a;
    b4.b = b;
    b4.valid = 1'b1;
    wait_n = 0;
    while (b4.ready !== 1'b1 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    if (!keep_valid) b4.valid = 1'b0;
    lat = 1;
    rl = 1'b1;
    while (b4.done !== 1'b1 && lat < 60) begin
      if (b4.ready !== 1'b0) rl = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (b4.ready !== 1'b0) rl = 1'b0;
    e = sb.pop_front();
    total++;
    if (lat !== 13) begin
      bad++;
      $display("FAIL %s latency: got %0d want 13", tag, lat);
    end
    total++;
    if (b4.result !== e.res[7:0]) begin
      bad++;
      $display("FAIL %s result: got %0d want %0d", tag, b4.result, e.res[7:0]);
    end
    total++;
    if (b4.segments !== e.seg[20:0]) begin
      bad++;
      $display("FAIL %s segments: got %h want %h", tag, b4.segments, e.seg[20:0]);
    end
    total++;
    if (rl !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_busy: got ready high while busy, want low", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b4.valid = 1'b0; b4.a = '0; b4.b = '0;
    b8.valid = 1'b0; b8.a = '0; b8.b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (b4.done !== 1'b0 || b4.ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctl: got done=%b ready=%b want done=0 ready=1", b4.done, b4.ready);
    end
    total++;
    if (b4.result !== 8'd0) begin
      bad++;
      $display("FAIL reset_result: got %0d want 0", b4.result);
    end
    total++;
    if (b4.segments !== model_seg(0, 3)) begin
      bad++;
      $display("FAIL reset_seg4: got %h want %h", b4.segments, model_seg(0, 3));
    end
    total++;
    if (b8.segments !== model_seg(0, 5)) begin
      bad++;
      $display("FAIL reset_seg8: got %h want %h", b8.segments, model_seg(0, 5));
    end
  endtask

  task automatic test_basic();
    int w;
    logic [7:0] held;
    run4(4'd15, 4'd15, 1'b0, "mul_15x15", w);
    @(negedge clk);
    total++;
    if (b4.done !== 1'b0 || b4.ready !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: got done=%b ready=%b want done=0 ready=1", b4.done, b4.ready);
    end
    held = 8'd225;
    b4.a = 4'd3; b4.b = 4'd3;
    repeat (5) @(negedge clk);
    total++;
    if (b4.result !== held) begin
      bad++;
      $display("FAIL result_hold: got %0d want %0d", b4.result, held);
    end
    run4(4'd0, 4'd9, 1'b0, "mul_0x9", w);
    run4(4'd9, 4'd0, 1'b0, "mul_9x0", w);
  endtask

  task automatic test_back_to_back();
    int w;
    run4(4'd7, 4'd8, 1'b1, "b2b_first", w);
    run4(4'd3, 4'd4, 1'b1, "b2b_second", w);
    total++;
    if (w !== 1) begin
      bad++;
      $display("FAIL b2b_gap: got %0d cycles to transfer want 1", w);
    end
    b4.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_blank();
    int w;
    run4(4'd3, 4'd3, 1'b0, "mul_3x3", w);
    run4(4'd10, 4'd10, 1'b0, "mul_10x10", w);
  endtask

  task automatic test_random();
    int w;
    logic [3:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      run4(a, b, 1'b0, "rand", w);
    end
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    b4.a = 4'd9; b4.b = 4'd9; b4.valid = 1'b1;
    n = 0;
    while (b4.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b4.valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (b4.done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_done: got o_done pulse want none");
    end
    total++;
    if (b4.result !== 8'd0 || b4.segments !== model_seg(0, 3)) begin
      bad++;
      $display("FAIL abort_outputs: got %0d/%h want 0/%h", b4.result, b4.segments, model_seg(0, 3));
    end
    total++;
    if (b4.ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready: got %b want 1", b4.ready);
    end
  endtask

  task automatic test_wide();
    exp_t e;
    int n, lat;
    e.res = 16'd65025;
    e.seg = model_seg(65025, 5);
    sb.push_back(e);
    b8.a = 8'd255; b8.b = 8'd255; b8.valid = 1'b1;
    n = 0;
    while (b8.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b8.valid = 1'b0;
    lat = 1;
    while (b8.done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    total++;
    if (lat !== 25) begin
      bad++;
      $display("FAIL wide_latency: got %0d want 25", lat);
    end
    total++;
    if (b8.result !== e.res) begin
      bad++;
      $display("FAIL wide_result: got %0d want %0d", b8.result, e.res);
    end
    total++;
    if (b8.segments !== e.seg) begin
      bad++;
      $display("FAIL wide_segments: got %h want %h", b8.segments, e.seg);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_blank();
    test_random();
    test_abort();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
